// File: rtl/csr_file_if.sv
// CSR file bus: writeback write port, execute read port, trap/mret events and
// the registered redirect outputs. Master drives requests; slave is the CSR file.
interface csr_file_if;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [11:0] raddr_i;
  logic [63:0] rdata_o;
  logic        illegal_o;
  logic        retire_i;
  logic        trap_i;
  logic [63:0] trap_pc_i;
  logic [63:0] trap_cause_i;
  logic        mret_i;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;

  modport master (
    output csr_wen_i, csr_addr_i, csr_wdata_i, raddr_i,
    output retire_i, trap_i, trap_pc_i, trap_cause_i, mret_i,
    input  rdata_o, illegal_o, mtvec_o, mepc_o
  );

  modport slave (
    input  csr_wen_i, csr_addr_i, csr_wdata_i, raddr_i,
    input  retire_i, trap_i, trap_pc_i, trap_cause_i, mret_i,
    output rdata_o, illegal_o, mtvec_o, mepc_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR storage: trap CSRs, cycle/instret counters, trap/mret updates.
// Optional CSR_BYPASS_EN forwards a same-cycle write to the combinational read port.
module csr_file #(
  parameter logic [63:0] HARTID = 64'd0
) (
  input logic  clock,
  input logic  reset,
  csr_file_if.slave bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [63:0] data;
  } csr_wr_t;

  csr_wr_t     wr;
  logic        mie, mpie;
  logic [63:0] mtvec, mscratch, mepc, mcause, mcycle, minstret;
  logic [63:0] mstatus_rd;
  logic        w_mstatus, w_mtvec, w_mscratch, w_mepc, w_mcause, w_mcycle, w_minstret;

  function automatic logic writable(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC,
      A_MCAUSE, A_MCYCLE, A_MINSTRET: writable = 1'b1;
      default:                        writable = 1'b0;
    endcase
  endfunction

  // Value a write would make visible on the read port, fields masked.
  function automatic logic [63:0] wr_view(input logic [11:0] a, input logic [63:0] d);
    case (a)
      A_MSTATUS:      wr_view = {51'd0, 2'b11, 3'd0, d[7], 3'd0, d[3], 3'd0};
      A_MTVEC, A_MEPC: wr_view = {d[63:2], 2'b00};
      default:        wr_view = d;
    endcase
  endfunction

  assign wr = '{en: bus.csr_wen_i, addr: bus.csr_addr_i, data: bus.csr_wdata_i};

  assign w_mstatus  = wr.en && (wr.addr == A_MSTATUS);
  assign w_mtvec    = wr.en && (wr.addr == A_MTVEC);
  assign w_mscratch = wr.en && (wr.addr == A_MSCRATCH);
  assign w_mepc     = wr.en && (wr.addr == A_MEPC);
  assign w_mcause   = wr.en && (wr.addr == A_MCAUSE);
  assign w_mcycle   = wr.en && (wr.addr == A_MCYCLE);
  assign w_minstret = wr.en && (wr.addr == A_MINSTRET);

  always_ff @(posedge clock) begin
    if (reset) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      // A counter write replaces that cycle's increment outright.
      mcycle <= w_mcycle ? wr.data : mcycle + 64'd1;
      if (w_minstret)         minstret <= wr.data;
      else if (bus.retire_i)  minstret <= minstret + 64'd1;

      if (w_mtvec)    mtvec    <= {wr.data[63:2], 2'b00};
      if (w_mscratch) mscratch <= wr.data;

      // Trap beats mret beats CSR write for the trap-state registers.
      if (bus.trap_i) begin
        mepc   <= {bus.trap_pc_i[63:2], 2'b00};
        mcause <= bus.trap_cause_i;
        mpie   <= mie;
        mie    <= 1'b0;
      end else begin
        if (w_mepc)   mepc   <= {wr.data[63:2], 2'b00};
        if (w_mcause) mcause <= wr.data;
        if (bus.mret_i) begin
          mie  <= mpie;
          mpie <= 1'b1;
        end else if (w_mstatus) begin
          mie  <= wr.data[3];
          mpie <= wr.data[7];
        end
      end
    end
  end

  assign mstatus_rd = {51'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};

  always_comb begin
    bus.rdata_o   = '0;
    bus.illegal_o = 1'b0;
    case (bus.raddr_i)
      A_MSTATUS:            bus.rdata_o = mstatus_rd;
      A_MTVEC:              bus.rdata_o = mtvec;
      A_MSCRATCH:           bus.rdata_o = mscratch;
      A_MEPC:               bus.rdata_o = mepc;
      A_MCAUSE:             bus.rdata_o = mcause;
      A_MCYCLE, A_CYCLE:    bus.rdata_o = mcycle;
      A_MINSTRET, A_INSTRET: bus.rdata_o = minstret;
      A_MHARTID:            bus.rdata_o = HARTID;
      default:              bus.illegal_o = 1'b1;
    endcase
`ifdef CSR_BYPASS_EN
    if (!reset && wr.en && (wr.addr == bus.raddr_i) && writable(wr.addr))
      bus.rdata_o = wr_view(wr.addr, wr.data);
`else
    if (1'b0 && writable(wr.addr)) bus.rdata_o = wr_view(wr.addr, wr.data);
`endif
  end

  assign bus.mtvec_o = mtvec;
  assign bus.mepc_o  = mepc;

endmodule
